// File: rtl/io_pio_debounce.sv
// io_pio_debounce: per-bit synchroniser and debouncer for raw board inputs.
// Each bit has its own synchroniser chain, acceptance counter and output
// register. Produces a stable `pio` level plus one-cycle rise/fall pulses.
// Optional sticky edge flags are compiled in when IO_PIO_EDGE_CAPTURE_EN
// is defined; without it the edge_clr/edge_flags ports do not exist.
module io_pio_debounce #(
    parameter int unsigned      WIDTH           = 8,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 500000,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] pio,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`ifdef IO_PIO_EDGE_CAPTURE_EN
    ,
    input  logic [WIDTH-1:0] edge_clr,
    output logic [WIDTH-1:0] edge_flags
`endif
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] accept;
    logic [CW-1:0]    cnt [WIDTH];

    // Synchroniser chain: raw enters stage 0, last stage is the clean level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= raw;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // A bit is accepted when it has differed from pio for DEBOUNCE_CYCLES edges.
    always_comb begin
        accept = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            accept[i] = (s[i] != pio[i]) && (cnt[i] == CNT_LAST);
        end
    end

    // Per-bit stability counters; any return to pio or an acceptance restarts them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if ((s[i] == pio[i]) || accept[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Output levels and edge pulses update on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pio  <= RESET_VALUE;
            rise <= '0;
            fall <= '0;
        end else begin
            pio  <= (pio & ~accept) | (s & accept);
            rise <= accept & s;
            fall <= accept & ~s;
        end
    end

`ifdef IO_PIO_EDGE_CAPTURE_EN
    // Sticky edge flags; a new edge in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_flags <= '0;
        end else begin
            edge_flags <= (edge_flags & ~edge_clr) | rise | fall;
        end
    end
`endif

endmodule

// File: tb/tb_io_pio_debounce.sv
// Scoreboard bench for io_pio_debounce (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// A reference model predicts pio/rise/fall/edge_flags after every clock edge
// and queues them; a monitor pops and compares on the falling edge.
module tb_io_pio_debounce;

    localparam int unsigned W    = 4;
    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 4;
    localparam logic [W-1:0] RV  = '0;

    typedef struct {
        logic [W-1:0] pio;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] flags;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] raw = '0;
    logic [W-1:0] edge_clr = '0;
    logic [W-1:0] pio, rise, fall;
    logic [W-1:0] flags_dut;

    int unsigned ncmp = 0;
    int unsigned nfail = 0;

    exp_t exp_q[$];

    io_pio_debounce #(
        .WIDTH(W),
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .RESET_VALUE(RV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .raw(raw),
        .pio(pio),
        .rise(rise),
        .fall(fall)
`ifdef IO_PIO_EDGE_CAPTURE_EN
        ,
        .edge_clr(edge_clr),
        .edge_flags(flags_dut)
`endif
    );

`ifndef IO_PIO_EDGE_CAPTURE_EN
    assign flags_dut = '0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        ncmp++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    // Reference model: s at each edge is raw from SYNC edges earlier (RV right
    // after reset); a bit flips once its last DEB s-samples all oppose pio.
    logic [W-1:0] raw_hist[$];
    logic [W-1:0] s_hist[$];
    logic [W-1:0] m_pio, m_rise, m_fall, m_flags, s_now, acc;
    logic         m_fresh = 1'b1;
    bit           all_diff;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                raw_hist.delete();
                s_hist.delete();
                for (int k = 0; k < int'(SYNC); k++) raw_hist.push_back(RV);
                m_pio   = RV;
                m_rise  = '0;
                m_fall  = '0;
                m_flags = '0;
                m_fresh = 1'b1;
            end else begin
                s_now = raw_hist[raw_hist.size() - SYNC];
                raw_hist.push_back(raw);
                while (raw_hist.size() > SYNC) void'(raw_hist.pop_front());
                s_hist.push_back(s_now);
                while (s_hist.size() > DEB) void'(s_hist.pop_front());
`ifdef IO_PIO_EDGE_CAPTURE_EN
                m_flags = (m_flags & ~edge_clr) | m_rise | m_fall;
`endif
                acc = '0;
                for (int b = 0; b < int'(W); b++) begin
                    all_diff = (s_hist.size() >= DEB);
                    for (int j = 0; j < int'(s_hist.size()); j++) begin
                        if (s_hist[j][b] == m_pio[b]) all_diff = 1'b0;
                    end
                    acc[b] = all_diff;
                end
                m_rise = acc & s_now;
                m_fall = acc & ~s_now;
                m_pio  = m_pio ^ acc;
                exp_q.push_back('{pio: m_pio, rise: m_rise, fall: m_fall, flags: m_flags});
                m_fresh = 1'b0;
            end
        end
    end

    // Monitor: compare DUT against the oldest queued prediction each cycle.
    exp_t e;
    initial begin
        forever begin
            @(negedge clk);
            if (reset || (m_fresh && exp_q.size() == 0)) begin
                exp_q.delete();
                chk("reset_pio", pio, RV);
                chk("reset_rise", rise, '0);
                chk("reset_fall", fall, '0);
`ifdef IO_PIO_EDGE_CAPTURE_EN
                chk("reset_flags", flags_dut, '0);
`endif
            end else if (exp_q.size() == 0) begin
                ncmp++;
                nfail++;
                $display("FAIL scoreboard_empty at %0t: got no prediction, expected one", $time);
            end else begin
                e = exp_q.pop_front();
                chk("pio", pio, e.pio);
                chk("rise", rise, e.rise);
                chk("fall", fall, e.fall);
                chk("rise_fall_excl", rise & fall, '0);
`ifdef IO_PIO_EDGE_CAPTURE_EN
                chk("edge_flags", flags_dut, e.flags);
`endif
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [W-1:0] mask;

    initial begin
        // 1: raw=F during reset, then accepted after release
        reset = 1'b1;
        raw   = 4'hF;
        step(3);
        reset = 1'b0;
        step(10);
        // 2: glitch on bit 0 from pio=0
        raw = 4'h0;
        step(10);
        raw[0] = 1'b1;
        step(3);
        raw[0] = 1'b0;
        step(8);
        // 3: bounce on bit 1, then hold high
        for (int k = 0; k < 6; k++) begin
            raw[1] = ~raw[1];
            step(2);
        end
        raw[1] = 1'b1;
        step(10);
        // 4: independent falls from pio=F
        raw = 4'hF;
        step(10);
        raw[3:2] = 2'b00;
        step(2);
        raw[0] = 1'b0;
        step(10);
        // 5: reset while bit 2 is mid-count
        raw[2] = 1'b1;
        step(5);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(10);
        // 6: edge flag set and clear in the same cycle, then clear alone
        raw = 4'h0;
        step(10);
        raw[0] = 1'b1;
        step(6);
        edge_clr[0] = 1'b1;
        step(2);
        edge_clr = '0;
        step(4);
        // Random phase: sparse per-bit toggles, random clears, one reset
        for (int c = 0; c < 1500; c++) begin
            mask = '0;
            for (int b = 0; b < int'(W); b++) begin
                if ($urandom_range(4) == 0) mask[b] = 1'b1;
            end
            raw      = raw ^ mask;
            edge_clr = W'($urandom);
            reset    = (c >= 700 && c < 703);
            step(1);
        end
        reset    = 1'b0;
        edge_clr = '0;
        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at %0t: got no finish, expected finish", $time);
        nfail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $fatal(1, "timeout");
    end

endmodule
